rv32m_muldiv_unit: RTL

- Parametrised iterative multiply/divide unit implementing the RV32M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the EXE-stage ALU and is selected when opcode is RV32I_OPCODE_R and funct7 is 7'b0000001.
- Computes BITS_PER_CYCLE result bits per clock, with a valid/ready handshake on both sides so the pipeline can stall the EXE stage.
- Supports a pipeline flush that kills an in-flight operation.

---
 rtl/rv32m_muldiv_pkg.sv | 17 +
 rtl/rv32m_div_step.sv | 21 ++
 rtl/rv32m_muldiv_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rv32m_muldiv_pkg.sv
// Shared RV32M definitions: funct7/funct3 encodings and the mul/div FSM state type.
package rv32m_muldiv_pkg;

  localparam logic [6:0] RV32M_FUNCT7        = 7'b0000001;

  localparam logic [2:0] RV32M_FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] RV32M_FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] RV32M_FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] RV32M_FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] RV32M_FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] RV32M_FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] RV32M_FUNCT3_REM    = 3'b110;
  localparam logic [2:0] RV32M_FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} muldiv_state_t;

endpackage

// File: rtl/rv32m_div_step.sv
// One combinational restoring-divide step: shift in a dividend bit, subtract if it fits.
module rv32m_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // When the subtract fits, the true difference is below the divisor, so XLEN bits suffice.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted[XLEN-1:0] - divisor;
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, BITS_PER_CYCLE result bits per clock.
// Define RV32M_EARLY_OUT_EN to finish trivial operations (div-by-zero, overflow, mul by 0) right after accept.
module rv32m_muldiv_unit
  import rv32m_muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  muldiv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand magnitudes at the accept edge
  logic            op1_signed, op2_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op1_signed = (in_funct3 != RV32M_FUNCT3_MULHU) && (in_funct3 != RV32M_FUNCT3_DIVU) &&
                      (in_funct3 != RV32M_FUNCT3_REMU);
  assign op2_signed = op1_signed && (in_funct3 != RV32M_FUNCT3_MULHSU);
  assign a_neg      = op1_signed & in_op1[XLEN-1];
  assign b_neg      = op2_signed & in_op2[XLEN-1];
  assign a_mag      = a_neg ? -in_op1 : in_op1;
  assign b_mag      = b_neg ? -in_op2 : in_op2;

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     mul_sum;

  always_comb begin
    mul_next = acc_q;
    mul_sum  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      mul_sum  = {1'b0, mul_next[2*XLEN-1:XLEN]} + (mul_next[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, mul_next[XLEN-1:1]};
    end
  end

  // Restoring divide: acc = {partial remainder, dividend bits shifting into quotient}
  logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain;
  logic [BITS_PER_CYCLE-1:0]         q_bits;
  logic [2*XLEN-1:0]                 div_next;

  assign rem_chain[0] = acc_q[2*XLEN-1:XLEN];

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_div
    rv32m_div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[i]),
      .dvd_bit (acc_q[XLEN-1-i]),
      .divisor (b_q),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  assign div_next = {rem_chain[BITS_PER_CYCLE], acc_q[XLEN-BITS_PER_CYCLE-1:0], q_bits};

  // Sign correction; a zero divisor must leave the all-ones quotient untouched
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = (neg_res_q && !dz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (f3_q[2])                        fix_res = f3_q[1] ? rem : quo;
    else if (f3_q == RV32M_FUNCT3_MUL)  fix_res = prod[XLEN-1:0];
    else                                fix_res = prod[2*XLEN-1:XLEN];
  end

  logic            early_hit;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
`ifdef RV32M_EARLY_OUT_EN
    if (in_funct3[2]) begin
      if (in_op2 == '0) begin
        early_hit = 1'b1;
        early_res = in_funct3[1] ? in_op1 : '1;
      end else if (!in_funct3[0] && in_op1 == {1'b1, {(XLEN-1){1'b0}}} && in_op2 == '1) begin
        early_hit = 1'b1;
        early_res = in_funct3[1] ? '0 : in_op1;
      end
    end else if (in_op1 == '0 || in_op2 == '0) begin
      early_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          f3_d      = in_funct3;
          rd_d      = in_rd;
          acc_d     = {{XLEN{1'b0}}, in_funct3[2] ? a_mag : b_mag};
          b_d       = in_funct3[2] ? b_mag : a_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (in_op2 == '0);
          cnt_d     = CW'(ITER - 1);
          if (early_hit) begin
            result_d = early_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
        CALC: begin
          acc_d = f3_q[2] ? div_next : mul_next;
          if (cnt_q == '0) state_d = FIXUP;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FIXUP: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = result_q;
  assign out_rd     = rd_q;

endmodule
